// File: rtl/if_stage.sv
//==============================================================================
// Module      : if_stage
// Description : MIPS instruction-fetch stage: PC register, ROM addressing and
//               IF/ID pipeline register. Optional syscall halt via IF_HALT_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module if_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int          IMEM_AW  = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_data,
    output logic [31:0]        pc,
    output logic [31:0]        id_instr,
    output logic [31:0]        id_pc4,
    output logic               id_valid,
    output logic [31:0]        fetch_cnt,
    output logic               halted
);

    localparam logic [31:0] c_nop      = 32'h0000_0000;
    localparam logic [31:0] c_pc_step  = 32'd4;
    localparam logic [31:0] c_cnt_step = 32'd1;

    logic [31:0] r_pc;
    logic [31:0] r_id_instr;
    logic [31:0] r_id_pc4;
    logic        r_id_valid;
    logic [31:0] r_fetch_cnt;

    logic [31:0] w_pc4;
    logic [31:0] w_redirect_pc;
    logic        w_halted;
    logic        w_normal;

    assign w_pc4         = r_pc + c_pc_step;
    assign w_redirect_pc = {redirect_pc[31:2], 2'b00};

`ifdef IF_HALT_EN
    logic r_halted;
    logic w_syscall;

    assign w_syscall = (imem_data[31:26] == 6'h00) && (imem_data[5:0] == 6'h0C);
    assign w_halted  = r_halted;

    // Sticky until reset; redirects cannot restart a halted fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_halted <= 1'b0;
        end else if (w_normal && w_syscall) begin
            r_halted <= 1'b1;
        end
    end
`else
    assign w_halted = 1'b0;
`endif

    // Normal path: no redirect, no stall, not halted.
    assign w_normal = !redirect && !stall && !w_halted;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= PC_RESET;
        end else if (w_halted) begin
            r_pc <= r_pc;
        end else if (redirect) begin
            r_pc <= w_redirect_pc;
        end else if (stall) begin
            r_pc <= r_pc;
        end else begin
            r_pc <= w_pc4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_id_instr <= c_nop;
            r_id_pc4   <= 32'h0000_0000;
            r_id_valid <= 1'b0;
        end else if (w_halted || redirect) begin
            r_id_instr <= c_nop;
            r_id_pc4   <= 32'h0000_0000;
            r_id_valid <= 1'b0;
        end else if (stall) begin
            r_id_instr <= r_id_instr;
            r_id_pc4   <= r_id_pc4;
            r_id_valid <= r_id_valid;
        end else begin
            r_id_instr <= imem_data;
            r_id_pc4   <= w_pc4;
            r_id_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_cnt <= 32'h0000_0000;
        end else if (w_normal) begin
            r_fetch_cnt <= r_fetch_cnt + c_cnt_step;
        end
    end

    // Upper PC bits are dropped, so the ROM aliases across the address space.
    assign imem_addr = r_pc[IMEM_AW+1:2];
    assign pc        = r_pc;
    assign id_instr  = r_id_instr;
    assign id_pc4    = r_id_pc4;
    assign id_valid  = r_id_valid;
    assign fetch_cnt = r_fetch_cnt;
    assign halted    = w_halted;

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
//==============================================================================
// Module      : tb_if_stage
// Description : Directed self-checking bench for if_stage with a ROM model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_if_stage;

    localparam int c_aw = 10;

    logic            clk;
    logic            rst;
    logic            stall;
    logic            redirect;
    logic [31:0]     redirect_pc;
    logic [c_aw-1:0] imem_addr;
    logic [31:0]     imem_data;
    logic [31:0]     pc;
    logic [31:0]     id_instr;
    logic [31:0]     id_pc4;
    logic            id_valid;
    logic [31:0]     fetch_cnt;
    logic            halted;

    logic [31:0] rom [0:(1<<c_aw)-1];
    int n_cmp;
    int n_err;

    assign imem_data = rom[imem_addr];

    if_stage #(
        .PC_RESET (32'h0000_0000),
        .IMEM_AW  (c_aw)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .pc          (pc),
        .id_instr    (id_instr),
        .id_pc4      (id_pc4),
        .id_valid    (id_valid),
        .fetch_cnt   (fetch_cnt),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                             input logic [31:0] e_pc4, input logic e_valid, input logic [31:0] e_cnt);
        check({tag, ".pc"},    pc,                e_pc);
        check({tag, ".instr"}, id_instr,          e_instr);
        check({tag, ".pc4"},   id_pc4,            e_pc4);
        check({tag, ".valid"}, {31'd0, id_valid}, {31'd0, e_valid});
        check({tag, ".cnt"},   fetch_cnt,         e_cnt);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < (1 << c_aw); i++) rom[i] = 32'h0000_0000;
        rom[0]    = 32'h2008_0001;
        rom[1]    = 32'h2009_0002;
        rom[2]    = 32'h0109_5020;
        rom[3]    = 32'h0000_0000;
        rom[8]    = 32'hAABB_CCDD;
        rom[16]   = 32'h1234_5678;
        rom[1023] = 32'hCAFE_F00D;

        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        step();
        step();
        check_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        check("reset.halted", {31'd0, halted}, 32'd0);
        check("reset.addr", {22'd0, imem_addr}, 32'd0);

        // Sequential fetch, one-cycle latency into IF/ID
        rst = 1'b0;
        step(); check_all("seq1", 32'h4, 32'h2008_0001, 32'h4, 1'b1, 32'd1);
        step(); check_all("seq2", 32'h8, 32'h2009_0002, 32'h8, 1'b1, 32'd2);

        // Stall two cycles at pc=8
        stall = 1'b1;
        step(); check_all("stall1", 32'h8, 32'h2009_0002, 32'h8, 1'b1, 32'd2);
        step(); check_all("stall2", 32'h8, 32'h2009_0002, 32'h8, 1'b1, 32'd2);
        stall = 1'b0;
        step(); check_all("resume1", 32'hC, 32'h0109_5020, 32'hC, 1'b1, 32'd3);
        step(); check_all("resume2", 32'h10, 32'h0000_0000, 32'h10, 1'b1, 32'd4);

        // Redirect with unaligned target
        redirect = 1'b1; redirect_pc = 32'h0000_0043;
        step(); check_all("redir", 32'h40, 32'h0, 32'h0, 1'b0, 32'd4);
        redirect = 1'b0;
        step(); check_all("redir_next", 32'h44, 32'h1234_5678, 32'h44, 1'b1, 32'd5);

        // Redirect wins over simultaneous stall
        redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h0000_0020;
        step(); check_all("redir_stall", 32'h20, 32'h0, 32'h0, 1'b0, 32'd5);
        redirect = 1'b0; stall = 1'b0;
        check("redir_stall.addr", {22'd0, imem_addr}, 32'd8);
        step(); check_all("after_rs", 32'h24, 32'hAABB_CCDD, 32'h24, 1'b1, 32'd6);

        // PC wrap at top of address space
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        check("wrap.pc", pc, 32'hFFFF_FFFC);
        check("wrap.addr", {22'd0, imem_addr}, 32'h3FF);
        redirect = 1'b0;
        step(); check_all("wrap_next", 32'h0, 32'hCAFE_F00D, 32'h0, 1'b1, 32'd7);

        // Mid-operation reset, overriding a redirect
        rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h100;
        step(); check_all("midrst", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        rst = 1'b0; redirect = 1'b0;
        step(); check_all("midrst_next", 32'h4, 32'h2008_0001, 32'h4, 1'b1, 32'd1);

        // Syscall at ROM[2]: halts only when the feature is built in
        rst = 1'b1; rom[2] = 32'h0000_000C;
        step();
        rst = 1'b0;
        step();
        step();
        step();
        check("sys.instr", id_instr, 32'h0000_000C);
        check("sys.valid", {31'd0, id_valid}, 32'd1);
        check("sys.pc", pc, 32'hC);
        check("sys.cnt", fetch_cnt, 32'd3);
`ifdef IF_HALT_EN
        check("sys.halted", {31'd0, halted}, 32'd1);
        step(); check_all("halt1", 32'hC, 32'h0, 32'h0, 1'b0, 32'd3);
        redirect = 1'b1; redirect_pc = 32'h40;
        step(); check_all("halt_redir", 32'hC, 32'h0, 32'h0, 1'b0, 32'd3);
        check("halt_redir.halted", {31'd0, halted}, 32'd1);
        redirect = 1'b0; rst = 1'b1;
        step();
        check("halt_rst.halted", {31'd0, halted}, 32'd0);
        check("halt_rst.pc", pc, 32'h0);
        rst = 1'b0;
        step(); check_all("halt_rst_next", 32'h4, 32'h2008_0001, 32'h4, 1'b1, 32'd1);
`else
        check("sys.halted", {31'd0, halted}, 32'd0);
        step(); check_all("nohalt1", 32'h10, 32'h0, 32'h10, 1'b1, 32'd4);
        redirect = 1'b1; redirect_pc = 32'h40;
        step(); check_all("nohalt_redir", 32'h40, 32'h0, 32'h0, 1'b0, 32'd4);
        check("nohalt_redir.halted", {31'd0, halted}, 32'd0);
        redirect = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
